dma64_mem_responder: RTL and testbench
======================================

# dma64_mem_responder

Memory-side responder for the 64-bit ESP-style DMA interface that our RTL accelerators drive. It accepts read and write control requests, streams read data out of an internal word-addressed RAM, and absorbs write data into it. It stands in for the system memory/NoC end in accelerator testbenches and standalone FPGA bring-up.

## Interface
Parameters:
- ADDR_W, 10, RAM word-address width; depth = 2**ADDR_W 64-bit words.

Ports:
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- dma_read_ctrl_valid  in  1  read request valid.
- dma_read_ctrl_ready  out  1  read request accepted when valid&ready.
- dma_read_ctrl_data_index  in  32  start word index.
- dma_read_ctrl_data_length  in  32  beat count.
- dma_read_ctrl_data_size  in  3  beat size; only 3'b011 (64-bit) is legal.
- dma_read_ctrl_data_user  in  6  ignored.
- dma_read_chnl_valid  out  1  read beat valid.
- dma_read_chnl_ready  in  1  accelerator accepts beat.
- dma_read_chnl_data  out  64  read beat.
- dma_write_ctrl_valid/ready/data_index/data_length/data_size/data_user  same as the read ctrl ports.
- dma_write_chnl_valid  in  1  write beat valid.
- dma_write_chnl_ready  out  1  responder accepts beat.
- dma_write_chnl_data  in  64  write beat.
- err  out  1  sticky: illegal size seen.
- debug  out  32  {28'd0, 2'd0, state}.

## Operation
- States: IDLE, RD_STREAM, WR_STREAM.
- IDLE: both ctrl readies high. If read and write ctrl are valid in the same cycle, read wins; write stays pending (ready drops, valid must hold).
- On accept: latch index[ADDR_W-1:0] as address pointer, length as remaining count. Length 0 returns to IDLE with no beats.
- Size other than 3'b011: request is still accepted and served as 64-bit; err sets and holds until reset.
- RD_STREAM: sync RAM (1-cycle read latency) feeds a 2-entry output FIFO. A RAM read issues when FIFO occupancy plus in-flight reads is below 2 and issued < length. chnl_valid = FIFO non-empty; data = FIFO head. Exit to IDLE after the length-th handshake.
- WR_STREAM: chnl_ready high; each valid&ready writes mem[ptr], then ptr+1 and remaining-1. Exit to IDLE after the length-th beat.
- Address arithmetic is modulo 2**ADDR_W; index bits above ADDR_W are dropped and the pointer wraps from the top word to 0.
- Reset mid-transfer: all state, FIFO and counters clear and outputs return to reset values. RAM contents are not cleared.

## Timing
- Reset values: ctrl readies 0, read_chnl_valid 0, read_chnl_data 0, write_chnl_ready 0, err 0, debug 0. Ctrl readies rise in the first cycle after rst deasserts.
- Ctrl readies are registered: low in the cycle after an accept, high again in the cycle after the final beat handshake.
- Read: request accepted at edge T. The first RAM read is issued in cycle T+1, and read_chnl_valid is high from T+2. With ready held high, throughput is 1 beat/cycle. Backpressure never loses or duplicates beats.
- Write: accepted at T; write_chnl_ready is high from T+1. Data written at the handshake edge is readable by any later read request.
- Write data never bypasses into in-flight reads; requests are strictly serialized.

## Structure
- Package dma64_pkg: DMA_SIZE_64 = 3'b011, state enum, DATA_W = 64, CTRL_W = 32.
- Sub-module dma64_sp_ram: single-port synchronous RAM, 2**ADDR_W × 64, write-first not required (no same-cycle read and write to one address).
- Output FIFO and the FSM stay inline.

## Test plan
- Write 4 beats at index 0 (0x11..0x44), then read 4 from index 0 -> read beats 0x11,0x22,0x33,0x44 in order, first valid 2 cycles after read accept.
- Read of length 8 with chnl_ready toggled 1,0,0,1,… -> exactly 8 beats in order, none dropped or repeated; ctrl ready returns 1 cycle after the 8th handshake.
- Read and write ctrl valid in the same cycle -> read accepted first; write accepted when IDLE is re-entered.
- Write 3 beats at index 2**ADDR_W-1 -> words at top, 0 and 1 updated; a wrapped read returns the same three values.
- Length 0 request with size 3'b010 -> no channel beats, err=1, back in IDLE 1 cycle later.
- rst asserted mid-read after 2 of 6 beats -> read_chnl_valid drops immediately; after release ctrl readies rise and RAM data is intact.

Source files
------------

// File: rtl/dma64_pkg.sv
// ---------------------------------------------------------------------------
// dma64_pkg
// Shared definitions for the 64-bit DMA memory responder: bus widths, the
// only legal beat-size encoding, the responder state enum and a small helper
// that classifies a requested beat size.
// ---------------------------------------------------------------------------
package dma64_pkg;

    localparam int DATA_W = 64;
    localparam int CTRL_W = 32;

    localparam logic [2:0] DMA_SIZE_64 = 3'b011;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RD_STREAM = 2'd1,
        WR_STREAM = 2'd2
    } dma_state_e;

    function automatic logic is_legal_size(input logic [2:0] size);
        return size == DMA_SIZE_64;
    endfunction

endpackage

// File: rtl/dma64_sp_ram.sv
// ---------------------------------------------------------------------------
// dma64_sp_ram
// Single-port synchronous RAM, 2**ADDR_W words of DATA_W bits. One access per
// cycle: a write when en_i & we_i, otherwise a read whose data appears on
// rdata_o in the following cycle. Contents are never reset.
//
// Ports:
//   clk      clock
//   en_i     access enable
//   we_i     write enable (qualified by en_i)
//   addr_i   word address
//   wdata_i  write data
//   rdata_o  registered read data
// ---------------------------------------------------------------------------
module dma64_sp_ram
    import dma64_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              en_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (en_i) begin
            if (we_i) begin
                mem_q[addr_i] <= wdata_i;
            end else begin
                rdata_q <= mem_q[addr_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dma64_mem_responder.sv
// ---------------------------------------------------------------------------
// dma64_mem_responder
// Memory-side end of the 64-bit ESP-style DMA interface. Accepts one read or
// write control request at a time, streams read beats out of an internal
// word-addressed RAM through a 2-entry output FIFO, and absorbs write beats
// into the same RAM. Requests are strictly serialized.
//
// Ports:
//   clk, rst                      clock, asynchronous active-low reset
//   dma_read_ctrl_*               read request (index, length, size, user)
//   dma_read_chnl_*               read beat stream out
//   dma_write_ctrl_*              write request (index, length, size, user)
//   dma_write_chnl_*              write beat stream in
//   err                           sticky: a request with an illegal size was seen
//   debug                         {30'd0, state}
// ---------------------------------------------------------------------------
module dma64_mem_responder
    import dma64_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              dma_read_ctrl_valid,
    output logic              dma_read_ctrl_ready,
    input  logic [CTRL_W-1:0] dma_read_ctrl_data_index,
    input  logic [CTRL_W-1:0] dma_read_ctrl_data_length,
    input  logic [2:0]        dma_read_ctrl_data_size,
    input  logic [5:0]        dma_read_ctrl_data_user,
    output logic              dma_read_chnl_valid,
    input  logic              dma_read_chnl_ready,
    output logic [DATA_W-1:0] dma_read_chnl_data,
    input  logic              dma_write_ctrl_valid,
    output logic              dma_write_ctrl_ready,
    input  logic [CTRL_W-1:0] dma_write_ctrl_data_index,
    input  logic [CTRL_W-1:0] dma_write_ctrl_data_length,
    input  logic [2:0]        dma_write_ctrl_data_size,
    input  logic [5:0]        dma_write_ctrl_data_user,
    input  logic              dma_write_chnl_valid,
    output logic              dma_write_chnl_ready,
    input  logic [DATA_W-1:0] dma_write_chnl_data,
    output logic              err,
    output logic [31:0]       debug
);

    dma_state_e        state_q, state_d;
    logic              ctrl_rdy_q, ctrl_rdy_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [CTRL_W-1:0] remain_q, remain_d;
    logic [CTRL_W-1:0] issue_left_q, issue_left_d;
    logic              inflight_q, inflight_d;
    logic [DATA_W-1:0] fifo_q [2];
    logic [DATA_W-1:0] fifo_d [2];
    logic              fifo_wr_q, fifo_wr_d;
    logic              fifo_rd_q, fifo_rd_d;
    logic [1:0]        fifo_cnt_q, fifo_cnt_d;

    logic              rd_accept, wr_accept;
    logic              fifo_empty, fifo_push, fifo_pop;
    logic              rd_issue, rd_hs, wr_hs;
    logic              ram_en;
    logic [DATA_W-1:0] ram_rdata;
    logic              unused_inputs;

    assign unused_inputs = ^{dma_read_ctrl_data_user, dma_write_ctrl_data_user,
                             dma_read_ctrl_data_index[CTRL_W-1:ADDR_W],
                             dma_write_ctrl_data_index[CTRL_W-1:ADDR_W]};

    // Read has priority: the write ready is masked while a read request is
    // presented so a simultaneous write never sees a handshake.
    assign rd_accept = ctrl_rdy_q && dma_read_ctrl_valid;
    assign wr_accept = ctrl_rdy_q && dma_write_ctrl_valid && !dma_read_ctrl_valid;

    assign fifo_empty = (fifo_cnt_q == 2'd0);

    // A RAM read in flight behaves as a fall-through FIFO entry, so the beat
    // is visible the cycle after the RAM access rather than one cycle later.
    assign dma_read_chnl_valid = !fifo_empty || inflight_q;
    assign dma_read_chnl_data  = !fifo_empty ? fifo_q[fifo_rd_q]
                               : (inflight_q ? ram_rdata : '0);

    assign rd_hs     = dma_read_chnl_valid && dma_read_chnl_ready;
    assign fifo_pop  = rd_hs && !fifo_empty;
    assign fifo_push = inflight_q && !(fifo_empty && rd_hs);

    // Issue only while the FIFO plus the in-flight read leave room for the result.
    assign rd_issue = (state_q == RD_STREAM) && (issue_left_q != '0) &&
                      (({1'b0, fifo_cnt_q} + {2'b00, inflight_q}) < 3'd2);

    assign wr_hs  = (state_q == WR_STREAM) && dma_write_chnl_valid;
    assign ram_en = rd_issue || wr_hs;

    assign dma_read_ctrl_ready  = ctrl_rdy_q;
    assign dma_write_ctrl_ready = ctrl_rdy_q && !dma_read_ctrl_valid;
    assign dma_write_chnl_ready = (state_q == WR_STREAM);
    assign err                  = err_q;
    assign debug                = {28'd0, 2'd0, state_q};

    dma64_sp_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .en_i    (ram_en),
        .we_i    (wr_hs),
        .addr_i  (ptr_q),
        .wdata_i (dma_write_chnl_data),
        .rdata_o (ram_rdata)
    );

    always_comb begin
        state_d      = state_q;
        err_d        = err_q;
        ptr_d        = ptr_q;
        remain_d     = remain_q;
        issue_left_d = issue_left_q;
        inflight_d   = rd_issue;
        fifo_d       = fifo_q;
        fifo_wr_d    = fifo_wr_q;
        fifo_rd_d    = fifo_rd_q;
        fifo_cnt_d   = fifo_cnt_q;

        case (state_q)
            IDLE: begin
                if (rd_accept) begin
                    ptr_d        = dma_read_ctrl_data_index[ADDR_W-1:0];
                    remain_d     = dma_read_ctrl_data_length;
                    issue_left_d = dma_read_ctrl_data_length;
                    if (!is_legal_size(dma_read_ctrl_data_size)) err_d = 1'b1;
                    if (dma_read_ctrl_data_length != '0) state_d = RD_STREAM;
                end else if (wr_accept) begin
                    ptr_d    = dma_write_ctrl_data_index[ADDR_W-1:0];
                    remain_d = dma_write_ctrl_data_length;
                    if (!is_legal_size(dma_write_ctrl_data_size)) err_d = 1'b1;
                    if (dma_write_ctrl_data_length != '0) state_d = WR_STREAM;
                end
            end
            RD_STREAM: begin
                if (rd_issue) begin
                    ptr_d        = ptr_q + 1'b1;
                    issue_left_d = issue_left_q - 32'd1;
                end
                if (fifo_push) begin
                    fifo_d[fifo_wr_q] = ram_rdata;
                    fifo_wr_d         = ~fifo_wr_q;
                end
                if (fifo_pop) fifo_rd_d = ~fifo_rd_q;
                fifo_cnt_d = fifo_cnt_q + 2'(fifo_push) - 2'(fifo_pop);
                if (rd_hs) begin
                    remain_d = remain_q - 32'd1;
                    if (remain_q == 32'd1) state_d = IDLE;
                end
            end
            WR_STREAM: begin
                if (wr_hs) begin
                    ptr_d    = ptr_q + 1'b1;
                    remain_d = remain_q - 32'd1;
                    if (remain_q == 32'd1) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Ctrl readies drop for the cycle after any accept and come back the
    // cycle after the machine lands in IDLE.
    assign ctrl_rdy_d = (state_d == IDLE) && !(rd_accept || wr_accept);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            ctrl_rdy_q   <= 1'b0;
            err_q        <= 1'b0;
            ptr_q        <= '0;
            remain_q     <= '0;
            issue_left_q <= '0;
            inflight_q   <= 1'b0;
            fifo_q[0]    <= '0;
            fifo_q[1]    <= '0;
            fifo_wr_q    <= 1'b0;
            fifo_rd_q    <= 1'b0;
            fifo_cnt_q   <= 2'd0;
        end else begin
            state_q      <= state_d;
            ctrl_rdy_q   <= ctrl_rdy_d;
            err_q        <= err_d;
            ptr_q        <= ptr_d;
            remain_q     <= remain_d;
            issue_left_q <= issue_left_d;
            inflight_q   <= inflight_d;
            fifo_q       <= fifo_d;
            fifo_wr_q    <= fifo_wr_d;
            fifo_rd_q    <= fifo_rd_d;
            fifo_cnt_q   <= fifo_cnt_d;
        end
    end

endmodule

// File: tb/tb_dma64_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_dma64_mem_responder
// Directed plus randomized bench for the DMA memory responder. A plain array
// models the RAM; read expectations are the model words at consecutive
// (wrapping) addresses, captured when the read request is issued.
// ---------------------------------------------------------------------------
module tb_dma64_mem_responder;
    import dma64_pkg::*;

    localparam int ADDR_W = 10;
    localparam int DEPTH  = 1 << ADDR_W;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        dma_read_ctrl_valid = 1'b0;
    logic        dma_read_ctrl_ready;
    logic [31:0] dma_read_ctrl_data_index = '0;
    logic [31:0] dma_read_ctrl_data_length = '0;
    logic [2:0]  dma_read_ctrl_data_size = 3'b011;
    logic [5:0]  dma_read_ctrl_data_user = '0;
    logic        dma_read_chnl_valid;
    logic        dma_read_chnl_ready = 1'b0;
    logic [63:0] dma_read_chnl_data;
    logic        dma_write_ctrl_valid = 1'b0;
    logic        dma_write_ctrl_ready;
    logic [31:0] dma_write_ctrl_data_index = '0;
    logic [31:0] dma_write_ctrl_data_length = '0;
    logic [2:0]  dma_write_ctrl_data_size = 3'b011;
    logic [5:0]  dma_write_ctrl_data_user = '0;
    logic        dma_write_chnl_valid = 1'b0;
    logic        dma_write_chnl_ready;
    logic [63:0] dma_write_chnl_data = '0;
    logic        err;
    logic [31:0] debug;

    int errors = 0;
    int checks = 0;
    int wrAccepts = 0;
    logic [63:0] memModel [DEPTH];

    always #5 clk = ~clk;

    dma64_mem_responder #(.ADDR_W(ADDR_W)) dut (
        .clk                        (clk),
        .rst                        (rst),
        .dma_read_ctrl_valid        (dma_read_ctrl_valid),
        .dma_read_ctrl_ready        (dma_read_ctrl_ready),
        .dma_read_ctrl_data_index   (dma_read_ctrl_data_index),
        .dma_read_ctrl_data_length  (dma_read_ctrl_data_length),
        .dma_read_ctrl_data_size    (dma_read_ctrl_data_size),
        .dma_read_ctrl_data_user    (dma_read_ctrl_data_user),
        .dma_read_chnl_valid        (dma_read_chnl_valid),
        .dma_read_chnl_ready        (dma_read_chnl_ready),
        .dma_read_chnl_data         (dma_read_chnl_data),
        .dma_write_ctrl_valid       (dma_write_ctrl_valid),
        .dma_write_ctrl_ready       (dma_write_ctrl_ready),
        .dma_write_ctrl_data_index  (dma_write_ctrl_data_index),
        .dma_write_ctrl_data_length (dma_write_ctrl_data_length),
        .dma_write_ctrl_data_size   (dma_write_ctrl_data_size),
        .dma_write_ctrl_data_user   (dma_write_ctrl_data_user),
        .dma_write_chnl_valid       (dma_write_chnl_valid),
        .dma_write_chnl_ready       (dma_write_chnl_ready),
        .dma_write_chnl_data        (dma_write_chnl_data),
        .err                        (err),
        .debug                      (debug)
    );

    // Counts write-request handshakes so arbitration can be checked.
    always @(posedge clk) begin
        if (rst && dma_write_ctrl_valid && dma_write_ctrl_ready) wrAccepts++;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic stepClk();
        @(posedge clk);
        #1;
    endtask

    // One complete request. bpMode: 0 = channel always ready/valid,
    // 1 = read ready pattern 1,0,0,..., 2 = random gaps.
    // dataBase != 0 makes write beat i equal dataBase*(i+1).
    task automatic applyStimulus(input bit isRead, input logic [31:0] idx, input int len,
                                 input logic [2:0] size, input int bpMode,
                                 input logic [63:0] dataBase, input string tag);
        bit accepted = 0;
        int got = 0;
        int n = 0;
        int firstValid = -1;
        logic rdy;
        logic [63:0] beat;
        logic [63:0] expQ [$];
        for (int i = 0; i < len; i++)
            expQ.push_back(memModel[(int'(idx[ADDR_W-1:0]) + i) % DEPTH]);

        if (isRead) begin
            dma_read_ctrl_valid       = 1'b1;
            dma_read_ctrl_data_index  = idx;
            dma_read_ctrl_data_length = len;
            dma_read_ctrl_data_size   = size;
            dma_read_ctrl_data_user   = 6'($urandom);
        end else begin
            dma_write_ctrl_valid       = 1'b1;
            dma_write_ctrl_data_index  = idx;
            dma_write_ctrl_data_length = len;
            dma_write_ctrl_data_size   = size;
            dma_write_ctrl_data_user   = 6'($urandom);
        end
        for (int c = 0; c < 40 && !accepted; c++) begin
            if (isRead ? dma_read_ctrl_ready : dma_write_ctrl_ready) accepted = 1;
            stepClk();
        end
        dma_read_ctrl_valid  = isRead ? 1'b0 : dma_read_ctrl_valid;
        dma_write_ctrl_valid = isRead ? dma_write_ctrl_valid : 1'b0;
        checkOutput({tag, " accept"}, accepted, 1);
        if (!accepted) return;
        checkOutput({tag, " ctrl ready low after accept"}, dma_read_ctrl_ready, 0);

        if (len == 0) begin
            checkOutput({tag, " no beat"}, dma_read_chnl_valid, 0);
            stepClk();
            checkOutput({tag, " ctrl ready back"}, dma_read_ctrl_ready, 1);
            checkOutput({tag, " idle debug"}, debug, 0);
            return;
        end

        if (isRead) begin
            checkOutput({tag, " debug rd"}, debug, 1);
            while (got < len && n < 20 * len + 20) begin
                case (bpMode)
                    0:       rdy = 1'b1;
                    1:       rdy = (n % 3) == 0;
                    default: rdy = 1'($urandom_range(0, 1));
                endcase
                dma_read_chnl_ready = rdy;
                #0;
                if (dma_read_chnl_valid && firstValid < 0) firstValid = n;
                if (dma_read_chnl_valid && rdy) begin
                    checkOutput($sformatf("%s beat%0d", tag, got), dma_read_chnl_data, expQ[got]);
                    got++;
                end
                stepClk();
                n++;
            end
            dma_read_chnl_ready = 1'b0;
            checkOutput({tag, " first valid cycle"}, 64'(firstValid), 1);
            checkOutput({tag, " beat count"}, 64'(got), 64'(len));
            checkOutput({tag, " no extra beat"}, dma_read_chnl_valid, 0);
        end else begin
            checkOutput({tag, " chnl ready"}, dma_write_chnl_ready, 1);
            checkOutput({tag, " debug wr"}, debug, 2);
            while (got < len && n < 20 * len + 20) begin
                rdy  = (bpMode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
                beat = (dataBase != 0) ? dataBase * (got + 1) : {$urandom, $urandom};
                dma_write_chnl_valid = rdy;
                dma_write_chnl_data  = beat;
                if (rdy && dma_write_chnl_ready) begin
                    memModel[(int'(idx[ADDR_W-1:0]) + got) % DEPTH] = beat;
                    got++;
                end
                stepClk();
                n++;
            end
            dma_write_chnl_valid = 1'b0;
            checkOutput({tag, " beat count"}, 64'(got), 64'(len));
            checkOutput({tag, " chnl ready off"}, dma_write_chnl_ready, 0);
        end
        checkOutput({tag, " ctrl ready after last beat"}, dma_read_ctrl_ready, 1);
    endtask

    initial begin
        int len;
        int got;
        int n;
        int wrBefore;
        logic [31:0] idx;

        repeat (3) stepClk();
        checkOutput("reset rd ctrl ready", dma_read_ctrl_ready, 0);
        checkOutput("reset wr ctrl ready", dma_write_ctrl_ready, 0);
        checkOutput("reset rd chnl valid", dma_read_chnl_valid, 0);
        checkOutput("reset rd chnl data", dma_read_chnl_data, 0);
        checkOutput("reset wr chnl ready", dma_write_chnl_ready, 0);
        checkOutput("reset err", err, 0);
        checkOutput("reset debug", debug, 0);
        rst = 1'b1;
        checkOutput("ready before first edge", dma_read_ctrl_ready, 0);
        stepClk();
        checkOutput("rd ready after reset", dma_read_ctrl_ready, 1);
        checkOutput("wr ready after reset", dma_write_ctrl_ready, 1);

        // Basic write then read-back of 0x11..0x44.
        applyStimulus(0, 0, 4, 3'b011, 0, 64'h11, "wr4");
        applyStimulus(1, 0, 4, 3'b011, 0, 64'h0, "rd4");
        checkOutput("model word3", memModel[3], 64'h44);

        // Fill a scratch region used by the later reads.
        applyStimulus(0, 32, 32, 3'b011, 2, 64'h0, "fill");
        applyStimulus(1, 32, 8, 3'b011, 1, 64'h0, "rd8bp");

        // Simultaneous read and write requests: read wins.
        dma_write_ctrl_valid       = 1'b1;
        dma_write_ctrl_data_index  = 60;
        dma_write_ctrl_data_length = 2;
        dma_write_ctrl_data_size   = 3'b011;
        dma_read_ctrl_valid        = 1'b1;
        dma_read_ctrl_data_index   = 32;
        dma_read_ctrl_data_length  = 2;
        dma_read_ctrl_data_size    = 3'b011;
        #1;
        checkOutput("both valid wr ready", dma_write_ctrl_ready, 0);
        checkOutput("both valid rd ready", dma_read_ctrl_ready, 1);
        wrBefore = wrAccepts;
        applyStimulus(1, 32, 2, 3'b011, 0, 64'h0, "simRd");
        checkOutput("write held during read", 64'(wrAccepts - wrBefore), 0);
        applyStimulus(0, 60, 2, 3'b011, 0, 64'h5A, "simWr");
        checkOutput("write accepted once", 64'(wrAccepts - wrBefore), 1);
        applyStimulus(1, 60, 2, 3'b011, 2, 64'h0, "simChk");

        // Wrap at the top word; upper index bits are ignored.
        applyStimulus(0, 32'hABC0_03FF, 3, 3'b011, 0, 64'h0, "wrapWr");
        applyStimulus(1, 32'h0000_13FF, 3, 3'b011, 1, 64'h0, "wrapRd");
        applyStimulus(1, 32'h0000_0000, 2, 3'b011, 0, 64'h0, "wrapLow");
        checkOutput("err clean", err, 0);

        // Zero-length request with an illegal size.
        applyStimulus(1, 5, 0, 3'b010, 0, 64'h0, "len0");
        checkOutput("err sticky set", err, 1);
        stepClk();
        checkOutput("err holds", err, 1);

        // Random traffic inside the scratch region.
        for (int r = 0; r < 10; r++) begin
            len = $urandom_range(1, 6);
            idx = (32'($urandom_range(0, 1000)) << ADDR_W) | 32'(32 + $urandom_range(0, 32 - len));
            applyStimulus(1'($urandom_range(0, 1)), idx, len, 3'b011, 2, 64'h0,
                          $sformatf("rand%0d", r));
        end

        // Reset in the middle of a 6-beat read after 2 beats.
        dma_read_ctrl_valid       = 1'b1;
        dma_read_ctrl_data_index  = 40;
        dma_read_ctrl_data_length = 6;
        dma_read_ctrl_data_size   = 3'b011;
        n = 0;
        while (!dma_read_ctrl_ready && n < 20) begin
            stepClk();
            n++;
        end
        stepClk();
        dma_read_ctrl_valid = 1'b0;
        dma_read_chnl_ready = 1'b1;
        got = 0;
        n = 0;
        while (got < 2 && n < 20) begin
            if (dma_read_chnl_valid) begin
                checkOutput($sformatf("rstRd beat%0d", got), dma_read_chnl_data, memModel[40 + got]);
                got++;
            end
            stepClk();
            n++;
        end
        checkOutput("rstRd beats before reset", 64'(got), 2);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("rst valid drops", dma_read_chnl_valid, 0);
        checkOutput("rst data zero", dma_read_chnl_data, 0);
        checkOutput("rst ctrl ready", dma_read_ctrl_ready, 0);
        checkOutput("rst err cleared", err, 0);
        checkOutput("rst debug", debug, 0);
        dma_read_chnl_ready = 1'b0;
        stepClk();
        rst = 1'b1;
        checkOutput("ready low before edge", dma_read_ctrl_ready, 0);
        stepClk();
        checkOutput("ready after release", dma_read_ctrl_ready, 1);
        applyStimulus(1, 40, 6, 3'b011, 0, 64'h0, "postRst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
